// File: rtl/tdm_demux_8.sv
// TDM receive demux: serial slot stream to 8 parallel channels.
// Define TDM_PARITY_EN for 9-slot frames with an even-parity slot.
module tdm_demux_8 #(
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   din,
  input  logic           din_valid,
  input  logic           sof,
  output logic [8*W-1:0] y,
  output logic           frame_valid,
  output logic           frame_err,
  output logic [2:0]     slot
);

`ifdef TDM_PARITY_EN
  localparam logic [3:0] LAST = 4'd8;
`else
  localparam logic [3:0] LAST = 4'd7;
`endif

  typedef enum logic {HUNT, RUN} state_t;

  state_t         state;
  logic [3:0]     cnt;
  logic [3:0]     wr_idx;
  logic [8*W-1:0] shadow;
  logic [8*W-1:0] shadow_nxt;
  logic           early;

  // An sof beat always lands in slot 0, whatever the count says.
  assign wr_idx = sof ? 4'd0 : cnt;
  assign early  = (state == RUN) && sof && (cnt != 4'd0);
  assign slot   = (cnt == 4'd8) ? 3'd0 : cnt[2:0];

  always_comb begin
    shadow_nxt = shadow;
    for (int k = 0; k < 8; k++) begin
      if (wr_idx == 4'(k)) shadow_nxt[k*W +: W] = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      cnt         <= 4'd0;
      shadow      <= '0;
      y           <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (din_valid) begin
        if (state == HUNT) begin
          if (sof) begin
            shadow <= shadow_nxt;
            cnt    <= 4'd1;
            state  <= RUN;
          end
        end else if (early) begin
          frame_err <= 1'b1;
          shadow    <= shadow_nxt;
          cnt       <= 4'd1;
        end else if (cnt == LAST) begin
          cnt <= 4'd0;
`ifdef TDM_PARITY_EN
          if ((^shadow) == din[0]) begin
            y           <= shadow;
            frame_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
`else
          shadow      <= shadow_nxt;
          y           <= shadow_nxt;
          frame_valid <= 1'b1;
`endif
        end else begin
          shadow <= shadow_nxt;
          cnt    <= cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_8.sv
// Directed bench for tdm_demux_8.
// Default build checks 8-slot framing; TDM_PARITY_EN checks parity slot.
module tb_tdm_demux_8;

`ifdef TDM_PARITY_EN
  localparam int W = 4;
`else
  localparam int W = 1;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   din = '0;
  logic           din_valid = 1'b0;
  logic           sof = 1'b0;
  logic [8*W-1:0] y;
  logic           frame_valid;
  logic           frame_err;
  logic [2:0]     slot;

  int n_vec = 0;
  int n_bad = 0;

  tdm_demux_8 #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .sof         (sof),
    .y           (y),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .slot        (slot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic [W-1:0] d, input logic s);
    din = d;
    sof = s;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sof = 1'b0;
  endtask

  task automatic idle();
    din_valid = 1'b0;
    sof = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    din_valid = 1'b0;
    sof = 1'b0;
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

`ifndef TDM_PARITY_EN
  // Frame sender: checks frame_valid low on every beat but the last.
  task automatic send_frame(input logic [7:0] f, input logic s0,
                            input string tag);
    for (int k = 0; k < 8; k++) begin
      beat(f[k], (k == 0) ? s0 : 1'b0);
      if (k < 7) chk({tag, "_fv_mid"}, 64'(frame_valid), 64'd0);
    end
    chk({tag, "_fv"}, 64'(frame_valid), 64'd1);
    chk({tag, "_y"}, 64'(y), 64'(f));
    chk({tag, "_slot"}, 64'(slot), 64'd0);
  endtask
`endif

  initial begin
    do_reset();
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_fv", 64'(frame_valid), 64'd0);
    chk("rst_fe", 64'(frame_err), 64'd0);
    chk("rst_slot", 64'(slot), 64'd0);

`ifndef TDM_PARITY_EN
    // 1: basic frame
    beat(1'b1, 1'b1);
    chk("t1_slot1", 64'(slot), 64'd1);
    for (int k = 1; k < 8; k++) beat(1'((k + 1) % 2), 1'b0);
    chk("t1_fv", 64'(frame_valid), 64'd1);
    chk("t1_y", 64'(y), 64'h55);
    chk("t1_slot", 64'(slot), 64'd0);
    idle();
    chk("t1_fv_off", 64'(frame_valid), 64'd0);
    chk("t1_y_hold", 64'(y), 64'h55);

    // 2: beats without sof are ignored in HUNT
    do_reset();
    for (int k = 0; k < 10; k++) begin
      beat(1'b1, 1'b0);
      chk("t2_fv", 64'(frame_valid), 64'd0);
      chk("t2_slot", 64'(slot), 64'd0);
    end
    chk("t2_y", 64'(y), 64'd0);

    // 3: stalls between every beat
    do_reset();
    begin
      logic [7:0] f;
      f = 8'hA5;
      for (int k = 0; k < 8; k++) begin
        beat(f[k], k == 0);
        if (k < 7) chk("t3_fv_beat", 64'(frame_valid), 64'd0);
        else chk("t3_fv_last", 64'(frame_valid), 64'd1);
        idle();
        chk("t3_fv_idle", 64'(frame_valid), 64'd0);
        chk("t3_slot", 64'(slot), 64'((k + 1) % 8));
      end
      chk("t3_y", 64'(y), 64'hA5);
    end

    // 4: early sof aborts a partial frame
    do_reset();
    send_frame(8'hFF, 1'b1, "t4a");
    for (int k = 0; k < 4; k++) beat(1'b1, k == 0);
    beat(1'b0, 1'b1);
    chk("t4_fe", 64'(frame_err), 64'd1);
    chk("t4_fv_low", 64'(frame_valid), 64'd0);
    chk("t4_y_hold", 64'(y), 64'hFF);
    chk("t4_slot", 64'(slot), 64'd1);
    for (int k = 1; k < 8; k++) begin
      beat(1'b0, 1'b0);
      if (k == 1) chk("t4_fe_off", 64'(frame_err), 64'd0);
    end
    chk("t4_fv", 64'(frame_valid), 64'd1);
    chk("t4_y", 64'(y), 64'h00);

    // 5: back-to-back frames, free-running third, reset mid-frame
    do_reset();
    send_frame(8'h3C, 1'b1, "t5a");
    send_frame(8'hC3, 1'b1, "t5b");
    send_frame(8'h96, 1'b0, "t5c");
    for (int k = 0; k < 3; k++) beat(1'b1, k == 0);
    chk("t5_slot_mid", 64'(slot), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_y", 64'(y), 64'd0);
    chk("t5_async_slot", 64'(slot), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    beat(1'b1, 1'b0);
    chk("t5_hunt_slot", 64'(slot), 64'd0);
`else
    // 6: parity slot, correct then corrupted
    begin
      logic [31:0] f;
      logic        p;
      f = 32'h87654321;
      p = ^f;
      for (int k = 0; k < 8; k++) beat(f[k*4 +: 4], k == 0);
      chk("t6_slot8", 64'(slot), 64'd0);
      chk("t6_fv_pre", 64'(frame_valid), 64'd0);
      beat({3'b101, p}, 1'b0);
      chk("t6_fv", 64'(frame_valid), 64'd1);
      chk("t6_fe", 64'(frame_err), 64'd0);
      chk("t6_y", 64'(y), 64'h87654321);
      f = 32'h12345678;
      p = ~(^f);
      for (int k = 0; k < 8; k++) beat(f[k*4 +: 4], k == 0);
      beat({3'b000, p}, 1'b0);
      chk("t6_bad_fe", 64'(frame_err), 64'd1);
      chk("t6_bad_fv", 64'(frame_valid), 64'd0);
      chk("t6_bad_y", 64'(y), 64'h87654321);
      for (int k = 0; k < 8; k++) beat(f[k*4 +: 4], k == 0);
      beat(4'h3, 1'b1);
      chk("t6_early8", 64'(frame_err), 64'd1);
      chk("t6_early8_slot", 64'(slot), 64'd1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
